// File: rtl/pancham_arb_pkg.sv
// ---------------------------------------------------------------------------
// pancham_arb_pkg
// Shared definitions for the two-requester pancham (MD5) arbiter:
//   arb_state_t : arbiter FSM states
//   MSG_W       : message / digest width in bits
//   WID_W       : width of the message-length field
//   MAX_WIDTH   : longest message length the core accepts, in bits
// ---------------------------------------------------------------------------
package pancham_arb_pkg;

  localparam int MSG_W = 128;
  localparam int WID_W = 8;
  localparam logic [WID_W-1:0] MAX_WIDTH = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESULT,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/pancham_rr_pick.sv
// ---------------------------------------------------------------------------
// pancham_rr_pick
// Two-way round-robin pick. A lone request is granted directly; when both
// requesters ask at once the pointer decides who wins.
//   i_req   : request bits, bit N = requester N
//   i_ptr   : requester that has priority on a tie
//   o_grant : one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module pancham_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  // Pass single requests straight through and only use the pointer on a tie.
  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/pancham_arb.sv
// ---------------------------------------------------------------------------
// pancham_arb
// Shares one pancham MD5 core between two requesters. A job is accepted in
// IDLE, handed to the core once it is ready, and its digest (or an error for
// an oversized message or a core timeout) is returned on a one-cycle strobe.
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   reqN_valid/msg/width    : job offered by requester N (N = 0, 1)
//   reqN_ready              : one-cycle accept pulse to requester N
//   res_valid/id/err/digest : one-cycle result strobe and its payload
//   core_msg_in*            : job driven to the core
//   core_msg_output, core_msg_out_valid, core_ready : core responses
// Parameter TIMEOUT: BUSY cycles allowed before a job is aborted (2..255).
// ---------------------------------------------------------------------------
module pancham_arb
  import pancham_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [0:MSG_W-1] req0_msg,
  input  logic [0:WID_W-1] req0_width,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [0:MSG_W-1] req1_msg,
  input  logic [0:WID_W-1] req1_width,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic             res_err,
  output logic [0:MSG_W-1] res_digest,
  output logic [0:MSG_W-1] core_msg_in,
  output logic [0:WID_W-1] core_msg_in_width,
  output logic             core_msg_in_valid,
  input  logic [0:MSG_W-1] core_msg_output,
  input  logic             core_msg_out_valid,
  input  logic             core_ready
);

  // Last value of the BUSY counter before the job is declared lost.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_t       r_state;
  arb_state_t       w_nextState;
  logic             r_ptr;
  logic [1:0]       w_grant;
  logic             w_sel;
  logic [0:MSG_W-1] w_selMsg;
  logic [0:WID_W-1] w_selWidth;
  logic             w_badWidth;
  logic             w_accept;
  logic             w_start;
  logic             w_capture;
  logic             w_timeout;
  logic             r_id;
  logic             r_err;
  logic             r_coreValid;
  logic [0:MSG_W-1] r_msg;
  logic [0:WID_W-1] r_width;
  logic [0:MSG_W-1] r_digest;
  logic [7:0]       r_busyCnt;

  pancham_rr_pick u_pick (
    .i_req   ({req1_valid, req0_valid}),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_sel      = w_grant[1];
  assign w_selMsg   = w_sel ? req1_msg : req0_msg;
  assign w_selWidth = w_sel ? req1_width : req0_width;
  assign w_badWidth = (w_selWidth > MAX_WIDTH);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and handshake strobes. Accepts are suppressed while reset is
  // held so no requester sees a ready pulse for a job that would be dropped.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    res_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset && (w_grant != 2'b00)) begin
          w_accept    = 1'b1;
          w_nextState = w_badWidth ? RESULT : ISSUE;
        end
      end
      ISSUE: begin
        if (core_ready) begin
          w_start     = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (core_msg_out_valid) begin
          w_capture   = 1'b1;
          w_nextState = RESULT;
        end else if (r_busyCnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = RESULT;
        end
      end
      RESULT: begin
        res_valid   = 1'b1;
        w_nextState = core_ready ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (core_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign req0_ready = w_accept & w_grant[0];
  assign req1_ready = w_accept & w_grant[1];

  // Job datapath. The message and width are loaded only on a grant, so the
  // core inputs hold steady from ISSUE until the next job is accepted. The
  // core strobe is registered and therefore lands in the first BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_err       <= 1'b0;
      r_coreValid <= 1'b0;
      r_msg       <= '0;
      r_width     <= '0;
      r_digest    <= '0;
      r_busyCnt   <= '0;
    end else begin
      r_coreValid <= w_start;
      if (w_accept) begin
        r_ptr    <= w_grant[0];
        r_id     <= w_sel;
        r_err    <= w_badWidth;
        r_msg    <= w_selMsg;
        r_width  <= w_selWidth;
        r_digest <= '0;
      end
      if (w_start) begin
        r_busyCnt <= '0;
      end else if (r_state == BUSY) begin
        r_busyCnt <= r_busyCnt + 8'd1;
      end
      if (w_capture) begin
        r_digest <= core_msg_output;
        r_err    <= 1'b0;
      end else if (w_timeout) begin
        r_digest <= '0;
        r_err    <= 1'b1;
      end
    end
  end

  assign core_msg_in       = r_msg;
  assign core_msg_in_width = r_width;
  assign core_msg_in_valid = r_coreValid;
  assign res_id            = r_id;
  assign res_err           = r_err;
  assign res_digest        = r_digest;

endmodule
